// File: rtl/pbwc_motor_ctrl.sv
// rtl/pbwc_motor_ctrl.sv - push-button window motor controller with debounce, limits and travel timeout
module pbwc_motor_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TRAVEL_CYCLES   = 1000,
    parameter int CNT_W           = 16
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Press,
    input  logic       Limit_Open,
    input  logic       Limit_Closed,
    output logic       Open_CW,
    output logic       Close_CCW,
    output logic       Fault,
    output logic [2:0] State
);

    localparam logic [2:0] W_CLOSED  = 3'd0;
    localparam logic [2:0] W_OPENING = 3'd1;
    localparam logic [2:0] W_OPEN    = 3'd2;
    localparam logic [2:0] W_CLOSING = 3'd3;
    localparam logic [2:0] W_STOPPED = 3'd4;
    localparam logic [2:0] W_FAULT   = 3'd5;

    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_MAX     = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);

    logic [2:0]       state, state_nx;
    logic             last_dir_open, last_dir_open_nx;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] travel_cnt;
    logic             press_evt;
    logic             moving;
    logic             timeout;

    // Saturating at DEB_MAX means a held button yields a single event.
    assign press_evt = Press && (deb_cnt == DEB_LAST);
    assign moving    = (state == W_OPENING) || (state == W_CLOSING);
    assign timeout   = (travel_cnt == TRAVEL_LAST);

    always_comb begin
        state_nx         = state;
        last_dir_open_nx = last_dir_open;
        if (state != W_FAULT && Limit_Open && Limit_Closed) begin
            state_nx = W_FAULT;
        end else begin
            case (state)
                W_CLOSED: begin
                    if (press_evt) state_nx = W_OPENING;
                end
                W_OPENING: begin
                    if (Limit_Open) begin
                        state_nx = W_OPEN;
                    end else if (timeout) begin
                        state_nx = W_FAULT;
                    end else if (press_evt) begin
                        state_nx         = W_STOPPED;
                        last_dir_open_nx = 1'b1;
                    end
                end
                W_OPEN: begin
                    if (press_evt) state_nx = W_CLOSING;
                end
                W_CLOSING: begin
                    if (Limit_Closed) begin
                        state_nx = W_CLOSED;
                    end else if (timeout) begin
                        state_nx = W_FAULT;
                    end else if (press_evt) begin
                        state_nx         = W_STOPPED;
                        last_dir_open_nx = 1'b0;
                    end
                end
                W_STOPPED: begin
                    if (press_evt) state_nx = last_dir_open ? W_CLOSING : W_OPENING;
                end
                default: state_nx = W_FAULT;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state         <= W_CLOSED;
            last_dir_open <= 1'b0;
            deb_cnt       <= '0;
            travel_cnt    <= '0;
        end else begin
            state         <= state_nx;
            last_dir_open <= last_dir_open_nx;
            if (!Press) begin
                deb_cnt <= '0;
            end else if (deb_cnt != DEB_MAX) begin
                deb_cnt <= deb_cnt + 1'b1;
            end
            // Any state change restarts the timer, so each move begins at zero.
            if (state_nx != state) begin
                travel_cnt <= '0;
            end else if (moving) begin
                travel_cnt <= travel_cnt + 1'b1;
            end
        end
    end

    assign Open_CW   = (state == W_OPENING);
    assign Close_CCW = (state == W_CLOSING);
    assign Fault     = (state == W_FAULT);
    assign State     = state;

endmodule

// File: tb/tb_pbwc_motor_ctrl.sv
// tb/tb_pbwc_motor_ctrl.sv - scoreboard testbench for pbwc_motor_ctrl
module tb_pbwc_motor_ctrl;

    localparam int DEB    = 4;
    localparam int TRAVEL = 20;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Press;
    logic       Limit_Open;
    logic       Limit_Closed;
    logic       Open_CW;
    logic       Close_CCW;
    logic       Fault;
    logic [2:0] State;

    typedef struct {
        string      name;
        logic [2:0] st;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    pbwc_motor_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .TRAVEL_CYCLES  (TRAVEL),
        .CNT_W          (16)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Press       (Press),
        .Limit_Open  (Limit_Open),
        .Limit_Closed(Limit_Closed),
        .Open_CW     (Open_CW),
        .Close_CCW   (Close_CCW),
        .Fault       (Fault),
        .State       (State)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (sb.size() > 0) begin
            exp_t       e;
            logic [5:0] act, want;
            e    = sb.pop_front();
            act  = {Fault, Close_CCW, Open_CW, State};
            want = {e.st == 3'd5, e.st == 3'd3, e.st == 3'd1, e.st};
            compared++;
            if (act !== want) begin
                mismatched++;
                $display("FAIL %s: got state=%0d open=%b close=%b fault=%b, want state=%0d open=%b close=%b fault=%b",
                         e.name, State, Open_CW, Close_CCW, Fault, e.st, want[3], want[4], want[5]);
            end
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic expect_st(input string nm, input logic [2:0] s);
        exp_t e;
        e.name = nm;
        e.st   = s;
        sb.push_back(e);
    endtask

    task automatic do_press(input string nm, input logic [2:0] s);
        Press = 1'b1;
        repeat (DEB) step();
        expect_st(nm, s);
        Press = 1'b0;
        step();
    endtask

    initial begin
        Reset        = 1'b0;
        Press        = 1'b0;
        Limit_Open   = 1'b0;
        Limit_Closed = 1'b0;
        step();
        expect_st("reset_state", 3'd0);
        step();
        Reset = 1'b1;
        step();

        Press = 1'b1;
        repeat (DEB - 1) step();
        expect_st("short_press_3", 3'd0);
        Press = 1'b0;
        step();
        expect_st("short_press_release", 3'd0);

        do_press("press_to_opening", 3'd1);
        repeat (8) step();
        Limit_Open = 1'b1;
        step();
        expect_st("limit_open_stops", 3'd2);
        Limit_Open = 1'b0;
        do_press("press_to_closing", 3'd3);
        Limit_Closed = 1'b1;
        step();
        expect_st("limit_closed_stops", 3'd0);
        Limit_Closed = 1'b0;

        do_press("open_again", 3'd1);
        do_press("stop_mid_open", 3'd4);
        do_press("reverse_to_close", 3'd3);
        do_press("stop_mid_close", 3'd4);
        do_press("reverse_to_open", 3'd1);

        Press = 1'b1;
        repeat (DEB - 1) step();
        Limit_Open = 1'b1;
        step();
        expect_st("limit_beats_press", 3'd2);
        Press      = 1'b0;
        Limit_Open = 1'b0;
        step();
        step();
        expect_st("press_not_carried", 3'd2);

        Limit_Open   = 1'b1;
        Limit_Closed = 1'b1;
        step();
        expect_st("both_limits_fault", 3'd5);
        Limit_Open   = 1'b0;
        Limit_Closed = 1'b0;
        do_press("fault_absorbs_press", 3'd5);

        Reset = 1'b0;
        expect_st("reset_clears_fault", 3'd0);
        step();
        Reset = 1'b1;
        step();
        expect_st("after_reset_release", 3'd0);

        do_press("timeout_start", 3'd1);
        repeat (TRAVEL - 2) step();
        expect_st("still_driving_cycle19", 3'd1);
        step();
        expect_st("travel_timeout", 3'd5);
        do_press("timeout_ignores_press", 3'd5);

        Reset = 1'b0;
        step();
        Reset = 1'b1;
        step();
        do_press("close_test_open", 3'd1);
        Limit_Open = 1'b1;
        step();
        expect_st("close_test_at_open", 3'd2);
        Limit_Open = 1'b0;
        do_press("close_test_closing", 3'd3);
        #2;
        Reset = 1'b0;
        expect_st("async_reset_mid_close", 3'd0);
        step();
        Reset = 1'b1;
        step();
        expect_st("post_async_reset", 3'd0);

        Press = 1'b1;
        repeat (DEB) step();
        expect_st("held_press_first", 3'd1);
        repeat (6) step();
        expect_st("held_press_single", 3'd1);
        Press = 1'b0;
        step();

        for (int i = 0; i < 10 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending checks, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pbwc_motor_ctrl.md
# pbwc_motor_ctrl

Parametrised successor to the single-bit push-button window controller. Drives a window motor from one push-button: Press is debounced, each accepted press advances a six-state open/stop/close/reverse machine, limit switches end travel, and a travel timer flags a stalled motor. Sits between the front-panel button/limit-switch inputs and the motor driver (CW = open, CCW = close).

## Interface
- DEBOUNCE_CYCLES, 4: consecutive cycles Press must be sampled high to count as one press (≥1)
- TRAVEL_CYCLES, 1000: maximum cycles the motor may be driven per move before Fault (≥2)
- CNT_W, 16: width of debounce and travel counters; must hold TRAVEL_CYCLES and DEBOUNCE_CYCLES
- Clock  in  1  single clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-low reset
- Press  in  1  raw push-button, active high
- Limit_Open  in  1  fully-open limit switch, active high
- Limit_Closed  in  1  fully-closed limit switch, active high
- Open_CW  out  1  drive motor clockwise (opening)
- Close_CCW  out  1  drive motor counter-clockwise (closing)
- Fault  out  1  latched fault indicator
- State  out  3  current state code (diagnostic)

## Operation
- Press acceptance: debounce counter increments each edge Press=1, clears on Press=0, saturates. press_evt is true on the edge where Press is sampled high for the DEBOUNCE_CYCLES-th consecutive time; exactly one event per press, next event requires Press sampled low ≥1 cycle.
- States / codes: W_CLOSED=0, W_OPENING=1, W_OPEN=2, W_CLOSING=3, W_STOPPED=4, W_FAULT=5; codes 6,7 go to W_FAULT.
- Per-edge priority: (1) both limits high in any non-fault state -> W_FAULT; (2) limit/timeout rules; (3) press_evt.
- W_CLOSED: press_evt -> W_OPENING.
- W_OPENING: Limit_Open -> W_OPEN; travel timer == TRAVEL_CYCLES-1 without Limit_Open -> W_FAULT; else press_evt -> W_STOPPED, last_dir=open. Limit_Closed ignored.
- W_OPEN: press_evt -> W_CLOSING.
- W_CLOSING: Limit_Closed -> W_CLOSED; timeout as above -> W_FAULT; else press_evt -> W_STOPPED, last_dir=close. Limit_Open ignored.
- W_STOPPED: press_evt -> W_CLOSING if last_dir=open, else W_OPENING (reversal).
- W_FAULT: absorbing; exit only by Reset.
- Travel timer: cleared on entry to W_OPENING/W_CLOSING, increments each cycle in those states; motor therefore driven at most TRAVEL_CYCLES cycles per move.
- Outputs are Moore decodes of state: Open_CW=1 only in W_OPENING, Close_CCW=1 only in W_CLOSING (never both), Fault=1 only in W_FAULT, State = state code.

## Timing
- Reset asserted: state=W_CLOSED, last_dir=close, counters=0; Open_CW=0, Close_CCW=0, Fault=0, State=0 immediately (asynchronous), including mid-travel.
- Reset release: first transition possible on the first rising edge after deassertion; debounce restarts from 0.
- Press latency: outputs change one edge after press_evt, i.e. on the DEBOUNCE_CYCLES-th consecutive high sample.
- Limit latency: motor output drops on the first edge Limit is sampled high.
- Limit and press_evt on same edge: limit wins; press is consumed (no carry-over).
- Timeout and press_evt on same edge: timeout wins -> W_FAULT.
- Press held continuously: exactly one transition.

## Test plan
- Reset, DEBOUNCE_CYCLES=4: Press high 3 cycles then low -> no change, State=0; Press high 4 cycles -> Open_CW=1, State=1 after 4th edge.
- From W_OPENING, Limit_Open=1 at cycle 10 of travel -> Open_CW=0, State=2 next edge; press -> Close_CCW=1, Limit_Closed -> State=0.
- Mid-open press -> State=4, outputs 0; second press -> Close_CCW=1 (reversal); repeat from closing -> reverses to Open_CW=1.
- TRAVEL_CYCLES=20, no limits: Open_CW high exactly 20 cycles, then Fault=1, State=5; further presses ignored until Reset.
- Both limits high while W_OPEN -> Fault=1; Limit_Open and press_evt on same edge in W_OPENING -> State=2, not 4.
- Reset asserted mid-closing (async, between edges) -> Close_CCW=0 immediately; after release State=0, Fault=0.
